// File: rtl/cmsdk_apb_multitimer_if.sv
// APB slave bus bundle for the multi-channel timer.
interface cmsdk_apb_multitimer_if;
   logic        PSEL;
   logic        PENABLE;
   logic [11:2] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/cmsdk_apb_multitimer.sv
// NUM_CH independent APB-programmable down-counters, each with prescaler,
// sticky interrupt and compare-based PWM output.
module cmsdk_apb_multitimer #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned WIDTH  = 32
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   cmsdk_apb_multitimer_if.slave apb,
   input  logic [NUM_CH-1:0]     TIMCLKEN,
   output logic [NUM_CH-1:0]     TIMINT,
   output logic                  TIMINTC,
   output logic [NUM_CH-1:0]     PWMOUT
);

   typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

   // Page 0x78 holds INTSTATUS at 0xF00; CTRL keeps only its defined bits
   localparam logic [6:0] StatPage = 7'h78;
   localparam logic [8:0] CtrlMask = 9'h1ED;

   logic [6:0]        chan;
   logic [2:0]        ofs;
   logic              setup, chan_ok, is_stat, err, wr_ok, rd_ok;
   logic [31:0]       rdata;
   logic [31:0]       ch_rdata [NUM_CH];
   logic [NUM_CH-1:0] mis, pwm;
   state_e            state_q;
   logic              ready_q, slverr_q;
   logic [31:0]       prdata_q;

   assign chan    = apb.PADDR[11:5];
   assign ofs     = apb.PADDR[4:2];
   assign setup   = apb.PSEL & ~apb.PENABLE;
   assign chan_ok = chan < 7'(NUM_CH);
   assign is_stat = chan == StatPage;

   // Classify the access presented in its setup phase
   always_comb begin
      err = 1'b0;
      if (is_stat) begin
         err = apb.PWRITE & (ofs == 3'd0);
      end else if (!chan_ok) begin
         err = 1'b1;
      end else if (apb.PWRITE) begin
         err = (ofs == 3'd1) | (ofs == 3'd4) | (ofs == 3'd5) |
               ((ofs == 3'd2) & (apb.PWDATA[3:2] == 2'b11));
      end else begin
         err = ofs == 3'd3;
      end
   end

   assign wr_ok = setup & apb.PWRITE & ~err;
   assign rd_ok = setup & ~apb.PWRITE & ~err;

   // Select read data from the addressed channel or the status page
   always_comb begin
      rdata = '0;
      if (is_stat) begin
         if (ofs == 3'd0) rdata = 32'(mis);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (chan == 7'(i)) rdata = ch_rdata[i];
         end
      end
   end

   // Bus response sequencer: erroring accesses get one wait state then SLVERR
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= StIdle;
         ready_q  <= 1'b1;
         slverr_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         prdata_q <= rd_ok ? rdata : '0;
         unique case (state_q)
            StIdle: begin
               if (setup & err) begin
                  state_q <= StWait;
                  ready_q <= 1'b0;
               end
            end
            StWait: begin
               state_q  <= StErr;
               ready_q  <= 1'b1;
               slverr_q <= 1'b1;
            end
            default: begin
               state_q  <= StIdle;
               ready_q  <= 1'b1;
               slverr_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] load_q, value_q, cmp_q, next_val;
      logic [8:0]       ctrl_q;
      logic [7:0]       presc_q;
      logic [1:0]       ps;
      logic [31:0]      rd;
      logic             ris_q, pwm_q, sel, en, tick;
      logic             wr_load, wr_ctrl, wr_clr, wr_bg, wr_cmp;

      assign sel     = wr_ok & (chan == 7'(i));
      assign wr_load = sel & (ofs == 3'd0);
      assign wr_ctrl = sel & (ofs == 3'd2);
      assign wr_clr  = sel & (ofs == 3'd3);
      assign wr_bg   = sel & (ofs == 3'd6);
      assign wr_cmp  = sel & (ofs == 3'd7);

      assign ps   = ctrl_q[3:2];
      assign en   = ctrl_q[7] & TIMCLKEN[i];
      assign tick = en & ((ps == 2'b00) |
                          ((ps == 2'b01) & (presc_q[3:0] == 4'hF)) |
                          ((ps == 2'b10) & (presc_q == 8'hFF)));

      // Counter value after a tick; one-shot takes priority over periodic at zero
      always_comb begin
         if (value_q != '0)   next_val = value_q - WIDTH'(1);
         else if (ctrl_q[0])  next_val = '0;
         else if (ctrl_q[6])  next_val = load_q;
         else                 next_val = '1;
      end

      // Per-channel register readback
      always_comb begin
         rd = '0;
         case (ofs)
            3'd0, 3'd6: rd = 32'(load_q);
            3'd1:       rd = 32'(value_q);
            3'd2:       rd = 32'(ctrl_q);
            3'd4:       rd = 32'(ris_q);
            3'd5:       rd = 32'(ris_q & ctrl_q[5]);
            3'd7:       rd = 32'(cmp_q);
            default:    rd = '0;
         endcase
      end

      // Channel state: registers, prescaler, counter, interrupt and PWM
      always_ff @(posedge PCLK or negedge PRESETn) begin
         if (!PRESETn) begin
            load_q  <= '0;
            value_q <= '1;
            ctrl_q  <= 9'h020;
            cmp_q   <= '0;
            presc_q <= '0;
            ris_q   <= 1'b0;
            pwm_q   <= 1'b0;
         end else begin
            if (wr_load | wr_bg) load_q <= apb.PWDATA[WIDTH-1:0];
            if (wr_ctrl)         ctrl_q <= apb.PWDATA[8:0] & CtrlMask;
            if (wr_cmp)          cmp_q  <= apb.PWDATA[WIDTH-1:0];

            if (wr_load | wr_ctrl) presc_q <= '0;
            else if (en)           presc_q <= presc_q + 8'd1;

            // A LOAD write wins over a same-cycle tick
            if (wr_load)   value_q <= apb.PWDATA[WIDTH-1:0];
            else if (tick) value_q <= next_val;

            // Set beats clear when both land together
            if (tick & ~wr_load & (value_q == WIDTH'(1))) ris_q <= 1'b1;
            else if (wr_clr)                               ris_q <= 1'b0;

            pwm_q <= ctrl_q[8] & ctrl_q[7] & (value_q < cmp_q);
         end
      end

      assign ch_rdata[i] = rd;
      assign mis[i]      = ris_q & ctrl_q[5];
      assign pwm[i]      = pwm_q;
   end

   assign TIMINT      = mis;
   assign TIMINTC     = |mis;
   assign PWMOUT      = pwm;
   assign apb.PRDATA  = prdata_q;
   assign apb.PREADY  = ready_q;
   assign apb.PSLVERR = slverr_q;

endmodule

// File: doc/cmsdk_apb_multitimer.md
Name: cmsdk_apb_multitimer

Overview:
Parametrised APB timer block that generalises the dual timer to NUM_CH independent down-counters of WIDTH bits. Each channel has its own mode, prescaler, interrupt and a new compare-based PWM output. Sits in the APB subsystem alongside the existing peripherals, on the same bus clock and reset.

Parameters:
NUM_CH, 4, number of timer channels (1..8).
WIDTH, 32, counter/load/compare width (8..32).

Ports:
PCLK  in  1  APB and timer clock; the only clock in the block.
PRESETn  in  1  reset, asynchronous, active-low.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PADDR  in  [11:2]  APB word address.
PWRITE  in  1  APB write.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data; registered.
PREADY  out  1  APB ready.
PSLVERR  out  1  APB error.
TIMCLKEN  in  NUM_CH  per-channel count enable, sampled on PCLK.
TIMINT  out  NUM_CH  per-channel masked interrupt.
TIMINTC  out  1  OR of TIMINT.
PWMOUT  out  NUM_CH  per-channel PWM output; registered.

Behaviour:
- Reset values:
  - PRDATA 0, PSLVERR 0, PREADY 1, TIMINT/TIMINTC/PWMOUT 0.
  - Per channel: LOAD 0, VALUE all ones (2^WIDTH-1), CTRL 0x020, CMP 0, RIS 0, prescaler 0.
- Address map:
  - Channel n occupies PADDR[11:5]==n.
  - Offsets: 0x00 LOAD RW; 0x04 VALUE RO; 0x08 CTRL RW; 0x0C INTCLR WO; 0x10 RIS RO; 0x14 MIS RO; 0x18 BGLOAD RW (reads LOAD); 0x1C CMP RW.
  - 0xF00 INTSTATUS RO: {zeros, MIS bits}, one bit per channel.
- CTRL bits: [0] ONESHOT, [3:2] PRESCALE (00 /1, 01 /16, 10 /256, 11 reserved), [5] INTEN, [6] PERIODIC, [7] ENABLE, [8] PWMEN.
  - Other bits read 0.
- APB timing:
  - Writes take effect on the setup-phase edge (PSEL & PWRITE & ~PENABLE).
  - Reads are registered on the setup-phase edge; PRDATA is valid in the access phase and is 0 otherwise.
- Errors:
  - Error conditions: access to channel index >= NUM_CH (other than page 0x78); write to VALUE, RIS, MIS or INTSTATUS; read of INTCLR; CTRL write with PRESCALE==11.
  - On error, the erroring access ignores the write, returns PRDATA 0, and gets one wait state: PREADY=0 for one cycle, then PREADY=1 with PSLVERR=1.
  - FSM: IDLE -> WAIT on error in setup phase; WAIT -> ERR; ERR -> IDLE.
- Width rules: writes truncate to WIDTH bits; reads zero-extend to 32.
- Prescaler:
  - 8-bit counter per channel, incremented on PCLK when ENABLE & TIMCLKEN[n].
  - tick = ENABLE & TIMCLKEN[n] & (PRESCALE==00, or prescaler[3:0]==0xF for 01, or prescaler==0xFF for 10).
  - The prescaler clears on a LOAD write or a CTRL write.
- Counter, on each tick:
  - If VALUE==0: periodic reloads LOAD; free-running (PERIODIC=0, ONESHOT=0) wraps to all ones; one-shot holds 0.
  - Otherwise VALUE decrements by 1.
  - Periodic period is therefore LOAD+1 ticks.
- LOAD write: LOAD and VALUE both take the new value on the next edge; this overrides any same-cycle tick.
- BGLOAD write: updates LOAD only; VALUE is untouched.
- Interrupt:
  - RIS sets on a tick where VALUE goes 1->0.
  - An INTCLR write (any data) clears RIS; a simultaneous set and clear leaves RIS=1.
  - MIS = RIS & INTEN; TIMINT[n] = MIS; TIMINTC = |TIMINT.
  - One-shot holding at 0 does not re-set RIS.
- PWM: PWMOUT[n] is registered as PWMEN & ENABLE & (VALUE < CMP).
  - CMP=0 gives constant low; CMP > LOAD gives constant high in periodic mode.
- Clearing ENABLE freezes VALUE and prescaler, and drives PWMOUT low on the next edge.
- PRESETn asserted mid-count returns all state to reset values immediately; the first tick after release decrements from all ones.

Test Plan:
- ch0: LOAD=3, CTRL=0xE0 (EN|PERIODIC|INTEN), TIMCLKEN=1 -> VALUE 3,2,1,0,3,2..; RIS/TIMINT[0]/TIMINTC rise when VALUE reaches 0, every 4 cycles; INTCLR write -> TIMINT[0]=0 next cycle.
- ch1: LOAD=2, ONESHOT|EN, INTEN=0 -> VALUE stops at 0; RIS=1, MIS=0, TIMINT[1]=0; INTSTATUS=0.
- ch2: LOAD=9, CMP=4, CTRL=0x1C0 (EN|PERIODIC|PWMEN) -> PWMOUT[2] high for 4 of every 10 cycles (VALUE 3..0); CMP=0 -> constant low.
- ch3: PRESCALE=01 (CTRL=0xC4), LOAD=1 -> VALUE decrements once per 16 PCLK; TIMCLKEN[3] held low -> VALUE frozen.
- Error cases:
  - With NUM_CH=4, write to 0x080 (channel 4) -> PREADY low 1 cycle, then PSLVERR=1, no state change.
  - Write to 0x004 -> same error.
  - CTRL write with PRESCALE=11 -> error and CTRL unchanged.
- Simultaneous events and reset:
  - INTCLR in the same cycle as the 1->0 tick -> RIS stays 1.
  - PRESETn pulse mid-count -> VALUE=0xFFFFFFFF, CTRL=0x20, all outputs 0.
